// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM.
// Sequences IF/ID/EX/MEM/WB from the instruction register fields and drives the
// datapath mux selects, write enables and the 3-bit ALUControlOp for the ALU.
// Control outputs are decoded from the registered state plus the live inputs;
// the halt causes and the retired-instruction counter are registered.
module multicycle_control #(
   parameter int unsigned MEM_WAIT_MAX = 0,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       Opcode,
   input  logic [2:0]       Func3,
   input  logic             Func7b5,
   input  logic             Bcond,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             PCSource,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUControlOp,
   output logic             Halted,
   output logic             IllegalInst,
   output logic             BusError,
   output logic [CNT_W-1:0] InstrCount,
   output logic [3:0]       StateOut
);

   typedef enum logic [3:0] {
      S_INIT = 4'd0,
      S_IF   = 4'd1,
      S_ID   = 4'd2,
      S_EX   = 4'd3,
      S_MEM  = 4'd4,
      S_WB   = 4'd5,
      S_HALT = 4'd6
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_R      = 3'b001;
   localparam logic [2:0] ALU_R_ALT  = 3'b101;
   localparam logic [2:0] ALU_I      = 3'b010;
   localparam logic [2:0] ALU_I_ALT  = 3'b110;
   localparam logic [2:0] ALU_BRANCH = 3'b011;
   localparam logic [2:0] ALU_PASSB  = 3'b111;

   localparam logic [31:0]      WAIT_LIM = MEM_WAIT_MAX;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_r;
   logic [CNT_W-1:0] instr_cnt_r;
   logic [31:0]      wait_cnt_r;
   logic             illegal_r;
   logic             bus_err_r;
   logic             timeout_s;
   logic             bcond_unused_s;

   // Opcodes that the datapath knows how to execute.
   function automatic logic is_exec_op(input logic [6:0] op);
      logic hit;
      case (op)
         OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: hit = 1'b1;
         default:                           hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Bcond qualifies PCWriteCond in the PC-enable gate of the datapath; the FSM
   // only requests the conditional load and never branches on Bcond itself.
   assign bcond_unused_s = Bcond;

   // The wait limit is hit on the MEM_WAIT_MAX-th consecutive not-ready cycle.
   assign timeout_s = (WAIT_LIM != 32'd0) && (wait_cnt_r == (WAIT_LIM - 32'd1));

   assign Halted      = (state_r == S_HALT);
   assign IllegalInst = illegal_r;
   assign BusError    = bus_err_r;
   assign InstrCount  = instr_cnt_r;
   assign StateOut    = state_r;

   // State sequencing, retire counting, memory wait timing and sticky halt causes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_INIT;
         instr_cnt_r <= '0;
         wait_cnt_r  <= 32'd0;
         illegal_r   <= 1'b0;
         bus_err_r   <= 1'b0;
      end else begin
         case (state_r)
            S_INIT: begin
               state_r    <= S_IF;
               wait_cnt_r <= 32'd0;
            end
            S_IF: begin
               if (MemReady) begin
                  state_r    <= S_ID;
                  wait_cnt_r <= 32'd0;
               end else if (timeout_s) begin
                  state_r    <= S_HALT;
                  bus_err_r  <= 1'b1;
                  wait_cnt_r <= 32'd0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 32'd1;
               end
            end
            S_ID: begin
               wait_cnt_r <= 32'd0;
               if (is_exec_op(Opcode)) begin
                  state_r <= S_EX;
               end else if (Opcode == OP_SYSTEM) begin
                  state_r <= S_HALT;
               end else begin
                  state_r   <= S_HALT;
                  illegal_r <= 1'b1;
               end
            end
            S_EX: begin
               wait_cnt_r <= 32'd0;
               case (Opcode)
                  OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_r <= S_WB;
                  OP_LOAD, OP_STORE: state_r <= S_MEM;
                  OP_BRANCH: begin
                     state_r     <= S_IF;
                     instr_cnt_r <= instr_cnt_r + CNT_ONE;
                  end
                  default: begin
                     state_r   <= S_HALT;
                     illegal_r <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (MemReady) begin
                  wait_cnt_r <= 32'd0;
                  case (Opcode)
                     OP_LOAD:  state_r <= S_WB;
                     OP_STORE: begin
                        state_r     <= S_IF;
                        instr_cnt_r <= instr_cnt_r + CNT_ONE;
                     end
                     default: begin
                        state_r   <= S_HALT;
                        illegal_r <= 1'b1;
                     end
                  endcase
               end else if (timeout_s) begin
                  state_r    <= S_HALT;
                  bus_err_r  <= 1'b1;
                  wait_cnt_r <= 32'd0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 32'd1;
               end
            end
            S_WB: begin
               state_r     <= S_IF;
               wait_cnt_r  <= 32'd0;
               instr_cnt_r <= instr_cnt_r + CNT_ONE;
            end
            S_HALT: begin
               state_r    <= S_HALT;
               wait_cnt_r <= 32'd0;
            end
            default: begin
               state_r    <= S_HALT;
               wait_cnt_r <= 32'd0;
            end
         endcase
      end
   end

   // Datapath control decode from the current state and the instruction fields.
   always_comb begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      PCSource     = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemtoReg     = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUControlOp = ALU_ADD;
      case (state_r)
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_ID: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
         end
         S_EX: begin
            case (Opcode)
               OP_RTYPE: begin
                  ALUSrcA      = 2'b01;
                  ALUControlOp = Func7b5 ? ALU_R_ALT : ALU_R;
               end
               OP_ITYPE: begin
                  ALUSrcA      = 2'b01;
                  ALUSrcB      = 2'b10;
                  ALUControlOp = ((Func3 == 3'b101) && Func7b5) ? ALU_I_ALT : ALU_I;
               end
               OP_LOAD, OP_STORE: begin
                  ALUSrcA = 2'b01;
                  ALUSrcB = 2'b10;
               end
               OP_BRANCH: begin
                  ALUSrcA      = 2'b01;
                  ALUControlOp = ALU_BRANCH;
                  PCWriteCond  = 1'b1;
                  PCSource     = 1'b1;
               end
               OP_LUI: begin
                  ALUSrcB      = 2'b10;
                  ALUControlOp = ALU_PASSB;
               end
               OP_AUIPC: begin
                  ALUSrcA = 2'b10;
                  ALUSrcB = 2'b10;
               end
               OP_JAL: begin
                  PCWrite  = 1'b1;
                  PCSource = 1'b1;
               end
               OP_JALR: begin
                  ALUSrcA = 2'b01;
                  ALUSrcB = 2'b10;
                  PCWrite = 1'b1;
               end
               default: begin
                  PCWrite = 1'b0;
               end
            endcase
         end
         S_MEM: begin
            IorD = 1'b1;
            case (Opcode)
               OP_LOAD:  MemRead  = 1'b1;
               OP_STORE: MemWrite = 1'b1;
               default:  MemRead  = 1'b0;
            endcase
         end
         S_WB: begin
            RegWrite = 1'b1;
            case (Opcode)
               OP_LOAD:          MemtoReg = 2'b01;
               OP_JAL, OP_JALR:  MemtoReg = 2'b10;
               default:          MemtoReg = 2'b00;
            endcase
         end
         default: begin
            RegWrite = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V (RV32I subset) main control FSM. Sits directly upstream of the ALU.
- Decodes the instruction register fields and sequences IF/ID/EX/MEM/WB.
- Drives the datapath mux selects, write enables, and the 3-bit ALUControlOp that the ALU consumes.
- Consumes the ALU's Bcond for conditional PC update.

Parameters:
- MEM_WAIT_MAX, 0, max cycles to wait for MemReady in IF/MEM; 0 = wait forever.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Opcode  in  7  IR[6:0]
- Func3  in  3  IR[14:12]
- Func7b5  in  1  IR[30]
- Bcond  in  1  branch condition from ALU, valid in EX of branch
- MemReady  in  1  memory access complete this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load iff Bcond
- PCSource  out  1  0 = ALU result, 1 = ALUOut register
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- RegWrite  out  1  register file write
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = OldPC+4 (link)
- ALUSrcA  out  2  00 = PC, 01 = rs1, 10 = OldPC
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- ALUControlOp  out  3  000 ADD, 001 R, 101 R_ (SUB/SRA), 010 I, 110 I_ (SRAI), 011 BRANCH, 111 ID (pass B)
- Halted  out  1  FSM in HALT
- IllegalInst  out  1  halt cause: undecoded opcode
- BusError  out  1  halt cause: MemReady timeout
- InstrCount  out  CNT_W  retired instructions
- StateOut  out  4  current state encoding (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values:
  - State = INIT, InstrCount = 0, wait counter = 0.
  - All control outputs, Halted, IllegalInst and BusError = 0.
- Output timing: outputs are combinational from the registered state plus Opcode/Func3/Func7b5/Bcond/MemReady. Any output not listed for a state is 0.
- INIT: all outputs 0; next state IF unconditionally.
- IF:
  - Drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUControlOp=ADD.
  - IRWrite = PCWrite = MemReady, with PCSource=0.
  - Stay in IF while MemReady=0; go to ID on MemReady=1.
- ID:
  - Drive ALUSrcA=10, ALUSrcB=10, ALUControlOp=ADD, so ALUOut = branch/JAL target.
  - Next state EX for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - 1110011 (ECALL/EBREAK) -> HALT.
  - Any other opcode -> HALT with IllegalInst latched to 1.
- EX, by opcode:
  - R: ALUSrcA=01, ALUSrcB=00; ALUControlOp = Func7b5 ? R_ : R. Next WB.
  - I: ALUSrcA=01, ALUSrcB=10; ALUControlOp = I_ when Func3=101 and Func7b5=1, else I (ADDI is never SUB). Next WB.
  - LOAD/STORE: ALUSrcA=01, ALUSrcB=10, ALUControlOp=ADD. Next MEM.
  - BRANCH: ALUSrcA=01, ALUSrcB=00, ALUControlOp=BRANCH, PCWriteCond=1, PCSource=1. Next IF (retire).
  - LUI: ALUSrcB=10, ALUControlOp=ID. Next WB.
  - AUIPC: ALUSrcA=10, ALUSrcB=10, ALUControlOp=ADD. Next WB.
  - JAL: PCWrite=1, PCSource=1. Next WB with link.
  - JALR: ALUSrcA=01, ALUSrcB=10, ALUControlOp=ADD, PCWrite=1, PCSource=0. Next WB with link.
- MEM:
  - IorD=1; MemRead=1 for LOAD, MemWrite=1 for STORE.
  - Hold in MEM until MemReady=1; the strobe stays asserted throughout.
  - On MemReady: LOAD -> WB; STORE -> IF (retire).
- WB: RegWrite=1 for exactly one cycle. MemtoReg = 01 for LOAD, 10 for JAL/JALR, 00 otherwise. Next IF (retire).
- Retire: InstrCount increments by 1 on each transition into IF from EX/MEM/WB. It wraps modulo 2^CNT_W. It does not count INIT->IF or HALT.
- Timeout (MEM_WAIT_MAX > 0):
  - The wait counter counts cycles in IF/MEM with MemReady=0 and clears on state change.
  - When it reaches MEM_WAIT_MAX with MemReady still 0 -> HALT, BusError latched to 1.
  - MemReady=1 in the same cycle as the limit takes priority (normal progress).
- HALT: sticky until reset_n. Halted=1, all enables 0, cause flags held.
- Reset mid-operation: an immediate return to INIT with all outputs 0. No partial write may complete.
- Latencies (MemReady=1 immediately):
  - ALU ops/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
  - Each MemReady=0 cycle adds 1.

Test Plan:
- Release reset, MemReady=1, IR=ADD (0110011, f3=000, f7b5=0) -> states INIT, IF, ID, EX (ALUControlOp=001, SrcA=01, SrcB=00), WB (RegWrite=1) -> IF; InstrCount=1.
- SUB and SRAI (0010011, f3=101, f7b5=1) -> EX ALUControlOp=101 and 110 respectively; ADDI with f7b5=1 -> 010.
- LW with MemReady low for 3 cycles in MEM -> MemRead and IorD held 1 for 4 MEM cycles, then WB MemtoReg=01; total 8 cycles IF-to-IF.
- BEQ with Bcond=1, then Bcond=0 -> EX PCWriteCond=1, PCSource=1, ALUControlOp=011, next IF both times; 3 cycles each; no RegWrite.
- Opcode 1111111 -> HALT after ID, IllegalInst=1, Halted=1, outputs frozen; then reset_n low asynchronously mid-cycle -> outputs 0 immediately, flags cleared.
- MEM_WAIT_MAX=4, MemReady stuck 0 in IF -> HALT after 4 cycles with BusError=1; InstrCount unchanged.
